// File: rtl/ysyx_22050133_radix2_divider.sv
// ---------------------------------------------------------------------------
// ysyx_22050133_radix2_divider
//
// Multi-cycle 64-bit restoring radix-2 divider that produces one quotient bit
// per cycle. It handles signed and unsigned operands, 64-bit operations and
// 32-bit (W) operations. Signed operands are divided as magnitudes, and the
// signs are applied to the final step. A zero divisor gives a quotient of all
// ones and the dividend as remainder. Signed overflow (MIN / -1) comes out of
// the magnitude path without a special case.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   flush      in   abort the in-flight division (no result is produced)
//   div_valid  in   request valid; accepted in IDLE when flush is low
//   divw       in   1 = 32-bit operation on operand bits [31:0]
//   div_signed in   1 = signed, 0 = unsigned
//   dividend   in   64-bit dividend
//   divisor    in   64-bit divisor
//   div_ready  out  idle, a request can be accepted
//   out_valid  out  single-cycle pulse: quotient/remainder are valid
//   quotient   out  quotient, held until the next accept
//   remainder  out  remainder, held until the next accept
// ---------------------------------------------------------------------------
module ysyx_22050133_radix2_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        div_valid,
  input  logic        divw,
  input  logic        div_signed,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        div_ready,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [5:0]  r_cnt;
  logic        r_divw;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_div_zero;
  logic [63:0] r_dvd;        // width-extended dividend, used for the divide-by-zero remainder
  logic [63:0] r_dvs;        // divisor magnitude
  logic [63:0] r_rem;        // partial remainder
  logic [63:0] r_quo;        // dividend bits shift out at the top, quotient bits shift in at the bottom
  logic [63:0] r_quotient;
  logic [63:0] r_remainder;

  // ---------------------------------------------------------------------------
  // Operand preparation (used only on the accept edge)
  // ---------------------------------------------------------------------------
  logic [63:0] w_dvd_ext;
  logic [63:0] w_dvs_ext;
  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [63:0] w_dvd_abs;
  logic [63:0] w_dvs_abs;
  logic        w_accept;
  logic        w_last;

  assign w_dvd_ext = divw ? {{32{div_signed & dividend[31]}}, dividend[31:0]} : dividend;
  assign w_dvs_ext = divw ? {{32{div_signed & divisor[31]}},  divisor[31:0]}  : divisor;
  assign w_dvd_neg = div_signed & w_dvd_ext[63];
  assign w_dvs_neg = div_signed & w_dvs_ext[63];
  assign w_dvd_abs = w_dvd_neg ? (64'd0 - w_dvd_ext) : w_dvd_ext;
  assign w_dvs_abs = w_dvs_neg ? (64'd0 - w_dvs_ext) : w_dvs_ext;

  assign w_accept  = (r_state == S_IDLE) && div_valid && !flush;
  assign w_last    = (r_cnt == (r_divw ? 6'd31 : 6'd63));

  // ---------------------------------------------------------------------------
  // One restoring step. The shifted remainder is 65 bits wide because a full
  // 64-bit divisor can leave a remainder that overflows 64 bits once doubled.
  // Bit 64 of the difference is the borrow: if it is set, the subtraction
  // underflowed, so the quotient bit is 0 and the shifted value is kept.
  // ---------------------------------------------------------------------------
  logic [64:0] w_shift;
  logic [64:0] w_diff;
  logic        w_qbit;
  logic [63:0] w_rem_next;
  logic [63:0] w_quo_next;

  assign w_shift    = {r_rem, r_quo[63]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[64];
  assign w_rem_next = w_qbit ? w_diff[63:0] : w_shift[63:0];
  assign w_quo_next = {r_quo[62:0], w_qbit};

  // ---------------------------------------------------------------------------
  // Final result, computed from the last step's outputs
  // ---------------------------------------------------------------------------
  logic [63:0] w_q_res;
  logic [63:0] w_r_res;

  always_comb begin
    w_q_res = r_divw ? {32'd0, w_quo_next[31:0]} : w_quo_next;
    w_r_res = w_rem_next;
    if (r_neg_q) w_q_res = 64'd0 - w_q_res;
    if (r_neg_r) w_r_res = 64'd0 - w_r_res;
    if (r_div_zero) begin
      w_q_res = '1;
      w_r_res = r_dvd;
    end
    if (r_divw) begin
      w_q_res = {{32{w_q_res[31]}}, w_q_res[31:0]};
      w_r_res = {{32{w_r_res[31]}}, w_r_res[31:0]};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge, whatever the statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_next = r_state;
    div_ready    = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        div_ready = 1'b1;
        if (div_valid && !flush) w_state_next = S_CALC;
      end
      S_CALC: begin
        if (flush)       w_state_next = S_IDLE;
        else if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter and visible results (reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= 6'd0;
      r_quotient  <= 64'd0;
      r_remainder <= 64'd0;
    end else if (w_accept) begin
      r_cnt <= 6'd0;
    end else if (r_state == S_CALC && !flush) begin
      r_cnt <= r_cnt + 6'd1;
      if (w_last) begin
        r_quotient  <= w_q_res;
        r_remainder <= w_r_res;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Working datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: these registers have no reset. Each accept loads every one of them
    // before it is read, so a reset would only cost routing.
    if (w_accept) begin
      r_divw     <= divw;
      r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r    <= w_dvd_neg;
      r_div_zero <= (w_dvs_ext == 64'd0);
      r_dvd      <= w_dvd_ext;
      r_dvs      <= w_dvs_abs;
      r_rem      <= 64'd0;
      // A W operation pre-shifts its 32-bit magnitude to the top, so 32 steps
      // leave the quotient in r_quo[31:0].
      r_quo      <= divw ? {w_dvd_abs[31:0], 32'd0} : w_dvd_abs;
    end else if (r_state == S_CALC) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule

// File: doc/ysyx_22050133_radix2_divider.md
YSYX_22050133_RADIX2_DIVIDER -- requirements
Module: ysyx_22050133_radix2_divider

Interface
REQ-001 SHALL have no parameters; the datapath is fixed at 64 bits.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-004 SHALL have port flush  in  1  abort the in-flight division.
REQ-005 SHALL have port div_valid  in  1  request valid.
REQ-006 SHALL have port divw  in  1  32-bit (W) operation.
REQ-007 SHALL have port div_signed  in  1  1 = signed, 0 = unsigned.
REQ-008 SHALL have port dividend  in  64  dividend operand.
REQ-009 SHALL have port divisor  in  64  divisor operand.
REQ-010 SHALL have port div_ready  out  1  idle; a request can be accepted.
REQ-011 SHALL have port out_valid  out  1  quotient and remainder are valid this cycle.
REQ-012 SHALL have port quotient  out  64  quotient result.
REQ-013 SHALL have port remainder  out  64  remainder result.

Function
REQ-014 SHALL implement states IDLE, CALC and DONE.
REQ-015 SHALL drive div_ready=1 only in IDLE.
REQ-016 SHALL drive out_valid=1 only in DONE.
REQ-017 SHALL accept a request at a rising edge where state=IDLE, div_valid=1 and flush=0.
REQ-018 SHALL, on accept, latch the operands, divw and div_signed, clear the iteration counter, and enter CALC.
REQ-019 SHALL ignore div_valid outside IDLE; the requester holds the request until div_ready=1.
REQ-020 SHALL, for divw=1, use dividend[31:0] and divisor[31:0], sign-extended if div_signed=1 and zero-extended otherwise.
REQ-021 SHALL, when signed, divide absolute values: quotient negated iff the operand signs differ; remainder carries the sign of the dividend.
REQ-022 SHALL perform restoring radix-2 division, one quotient bit per CALC cycle: 64 iterations for divw=0, 32 for divw=1.
REQ-023 SHALL leave CALC for DONE at the edge completing the last iteration.
REQ-024 SHALL therefore raise out_valid exactly 64 cycles after the accept edge (32 cycles when divw=1).
REQ-025 SHALL return from DONE to IDLE unconditionally at the next edge; out_valid is a single-cycle pulse.
REQ-026 SHALL hold quotient and remainder stable from DONE until the next accept.
REQ-027 SHALL, for a zero divisor (within the selected width), produce quotient = all ones and remainder = dividend (width-extended), with unchanged latency.
REQ-028 SHALL, for signed overflow (MIN / -1), produce quotient = MIN and remainder = 0 for the selected width.
REQ-029 SHALL, for divw=1, sign-extend bit 31 of both results to 64 bits, for signed and unsigned operation alike.
REQ-030 SHALL, on flush=1 in CALC or DONE, go to IDLE at the next edge with no out_valid and results unchanged.
REQ-031 SHALL, on flush=1 in IDLE, accept nothing.
REQ-032 SHALL contain no combinational path from any input to div_ready or out_valid.

Reset
REQ-033 SHALL, at an edge with rst=1, force state to IDLE, zero the counter, and clear quotient and remainder to 0, including mid-operation.
REQ-034 SHALL, in the first cycle after reset, drive div_ready=1 and out_valid=0.

Verification
REQ-035 SHALL cover unsigned 64-bit: 100 / 7 -> quotient=14, remainder=2, out_valid exactly 64 cycles after accept, 1 cycle wide.
REQ-036 SHALL cover signed 64-bit: -7 / 2 -> quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF.
REQ-037 SHALL cover signed divw: 0x80000000 / 0xFFFFFFFF -> quotient=0xFFFFFFFF80000000, remainder=0, out_valid at 32 cycles.
REQ-038 SHALL cover divide by zero: unsigned 5 / 0 -> quotient=all ones, remainder=5; divuw 0x100000005 / 0x100000000 -> quotient=all ones, remainder=5.
REQ-039 SHALL cover abort: flush at cycle 10 of CALC -> no out_valid, div_ready=1 next cycle; rst at cycle 20 -> outputs 0, div_ready=1.
REQ-040 SHALL cover back-to-back: div_valid held high across two requests -> the second is accepted only on the edge after DONE, both results correct.
